// File: rtl/jt12_wr_queue.sv
// jt12_wr_queue: FIFO write scheduler replaying CPU register writes onto the jt12 bus with cen-paced gaps.
// Optional JT12_WRQ_ADDR_SKIP_EN skips the address write when {port,reg} repeats the last one written.
module jt12_wr_queue #(
  parameter int AW        = 4,
  parameter int WAIT_ADDR = 4,
  parameter int WAIT_DATA = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          cpu_wr,
  input  logic          cpu_port,
  input  logic [7:0]    cpu_reg,
  input  logic [7:0]    cpu_val,
  output logic          full,
  output logic          empty,
  output logic          idle,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic [7:0]    ym_din,
  output logic [1:0]    ym_addr,
  output logic          ym_cs_n,
  output logic          ym_wr_n
);
  localparam int DEPTH = 2**AW;
  localparam int CW    = $clog2((WAIT_DATA > WAIT_ADDR ? WAIT_DATA : WAIT_ADDR) + 2);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AGAP, S_DATA, S_DGAP} st_t;
  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level, w_lvl;
  logic          r_full, r_empty, r_ovf;
  st_t           r_st, w_nst;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic          w_pop, w_push, w_skip;
  logic [16:0]   r_hold, w_head, w_ent;
  logic [7:0]    r_din;
  logic [1:0]    r_addr;
  logic          r_strb_n;
  assign w_head  = r_mem[r_rp];
  assign w_push  = cpu_wr && (!r_full || w_pop);
  assign w_lvl   = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_ent   = w_pop ? w_head : r_hold;
  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;
  assign ovf     = r_ovf;
  assign idle    = r_empty && (r_st == S_IDLE);
  assign ym_din  = r_din;
  assign ym_addr = r_addr;
  assign ym_cs_n = r_strb_n;
  assign ym_wr_n = r_strb_n;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {cpu_port, cpu_reg, cpu_val};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_wp    <= r_wp + AW'(w_push);
      r_rp    <= r_rp + AW'(w_pop);
      r_level <= w_lvl;
      r_full  <= w_lvl == (AW+1)'(DEPTH);
      r_empty <= w_lvl == '0;
      r_ovf   <= r_ovf | (cpu_wr & r_full & ~w_pop);
    end
  end
`ifdef JT12_WRQ_ADDR_SKIP_EN
  logic [8:0] r_last;
  logic       r_last_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= '0;
      r_last_v <= 1'b0;
    end else if (cen && r_st == S_ADDR) begin
      r_last   <= r_hold[16:8];
      r_last_v <= 1'b1;
    end
  end
  assign w_skip = r_last_v && (r_last == w_head[16:8]);
`else
  assign w_skip = 1'b0;
`endif
  always_comb begin
    w_nst  = r_st;
    w_ncnt = r_cnt;
    w_pop  = 1'b0;
    if (cen)
      case (r_st)
        S_IDLE: if (!r_empty) begin
          w_pop = 1'b1;
          w_nst = w_skip ? S_DATA : S_ADDR;
        end
        S_ADDR: begin
          w_nst  = (WAIT_ADDR == 0) ? S_DATA : S_AGAP;
          w_ncnt = CW'(WAIT_ADDR - 1);
        end
        S_AGAP: begin
          w_nst  = (r_cnt == '0) ? S_DATA : S_AGAP;
          w_ncnt = r_cnt - 1'b1;
        end
        S_DATA: begin
          w_nst  = (WAIT_DATA == 0) ? S_IDLE : S_DGAP;
          w_ncnt = CW'(WAIT_DATA - 1);
        end
        S_DGAP: begin
          w_nst  = (r_cnt == '0) ? S_IDLE : S_DGAP;
          w_ncnt = r_cnt - 1'b1;
        end
        default: w_nst = S_IDLE;
      endcase
  end
  // Bus pins are registered from the next state so the strobe spans exactly the ADDR/DATA cen cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= S_IDLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_strb_n <= 1'b1;
      r_din    <= '0;
      r_addr   <= '0;
    end else begin
      r_st     <= w_nst;
      r_cnt    <= w_ncnt;
      r_strb_n <= !(w_nst == S_ADDR || w_nst == S_DATA);
      if (w_pop) r_hold <= w_head;
      if (w_nst == S_ADDR) begin
        r_addr <= {w_ent[16], 1'b0};
        r_din  <= w_ent[15:8];
      end
      if (w_nst == S_DATA) begin
        r_addr <= {w_ent[16], 1'b1};
        r_din  <= w_ent[7:0];
      end
    end
  end
endmodule

// File: tb/tb_jt12_wr_queue.sv
// tb_jt12_wr_queue: directed and randomized checks of jt12_wr_queue against a write-order/timing model.
module tb_jt12_wr_queue;
  localparam int AW = 4, WA = 4, WD = 32, DEPTH = 16;
  logic clk = 0, rst = 1, cen = 1, cpu_wr = 0, cpu_port = 0;
  logic [7:0] cpu_reg = 0, cpu_val = 0;
  logic full, empty, idle, ovf, ym_cs_n, ym_wr_n;
  logic [AW:0] level;
  logic [7:0] ym_din;
  logic [1:0] ym_addr;
  int vectors = 0, miscompares = 0;
  int cyc = 0, t_cnt = 0, cen_mode = 0, ph = 0;
  logic [10:0] obs_ev[$];
  int obs_t[$], obs_len[$];
  logic [10:0] exp_ev[$];
  logic [8:0] m_last = 0;
  logic m_v = 0;
  logic mon_prev = 1;
  int mon_len = 0;

  jt12_wr_queue #(.AW(AW), .WAIT_ADDR(WA), .WAIT_DATA(WD)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_wr(cpu_wr), .cpu_port(cpu_port),
    .cpu_reg(cpu_reg), .cpu_val(cpu_val), .full(full), .empty(empty), .idle(idle),
    .level(level), .ovf(ovf), .ym_din(ym_din), .ym_addr(ym_addr),
    .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every strobe: {cs_n, addr, din} at its falling edge, start cycle and width in clks.
  always @(negedge clk) begin
    if (rst) begin
      if (!mon_prev) obs_len.push_back(mon_len);
      mon_prev = 1;
    end else begin
      if (!ym_wr_n && mon_prev) begin
        obs_ev.push_back({ym_cs_n, ym_addr, ym_din});
        obs_t.push_back(cyc);
        mon_len = 0;
      end
      if (!ym_wr_n) mon_len++;
      if (ym_wr_n && !mon_prev) obs_len.push_back(mon_len);
      mon_prev = ym_wr_n;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cpu_wr = 0;
    if (cen_mode == 0) cen = 1'b1;
    else if (cen_mode == 1) cen = (ph == 5);
    else cen = ($urandom_range(0, 2) == 0);
    ph = (ph + 1) % 6;
    t_cnt++;
  endtask

  task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v);
    cpu_wr = 1; cpu_port = p; cpu_reg = r; cpu_val = v;
    tick();
  endtask

  // Expected bus writes for one accepted entry, in pop order.
  task automatic add_entry(input logic p, input logic [7:0] r, input logic [7:0] v);
`ifdef JT12_WRQ_ADDR_SKIP_EN
    if (!(m_v && m_last == {p, r})) exp_ev.push_back({1'b0, p, 1'b0, r});
    m_last = {p, r};
    m_v = 1;
`else
    exp_ev.push_back({1'b0, p, 1'b0, r});
`endif
    exp_ev.push_back({1'b0, p, 1'b1, v});
  endtask

  task automatic push_m(input logic p, input logic [7:0] r, input logic [7:0] v);
    push(p, r, v);
    add_entry(p, r, v);
  endtask

  function automatic logic [7:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 8'h2A : 8'($urandom);
  endfunction

  task automatic push_rand();
    logic p;
    logic [7:0] r, v;
    p = 1'($urandom);
    r = rreg();
    v = 8'($urandom);
    push_m(p, r, v);
  endtask

  task automatic reset_dut();
    rst = 1;
    tick();
    tick();
    rst = 0;
    m_v = 0;
    exp_ev.delete();
  endtask

  task automatic wait_idle(input int maxc, output int k);
    k = 0;
    while (!idle && k < maxc) begin
      tick();
      k++;
    end
    chk("idle_reached", idle, 1);
  endtask

  task automatic check_events(input string tag, input int n0, input int len_exp);
    chk({tag, "_count"}, obs_ev.size() - n0, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && n0 + i < obs_ev.size(); i++) begin
      chk(tag, obs_ev[n0 + i], exp_ev[i]);
      if (len_exp > 0 && n0 + i < obs_len.size()) chk({tag, "_width"}, obs_len[n0 + i], len_exp);
    end
    exp_ev.delete();
  endtask

  initial begin
    int n0, n1, k, e0;
    logic [7:0] r;
    // reset state
    reset_dut();
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_din", ym_din, 0);
    chk("rst_addr", ym_addr, 0);
    chk("rst_cs_n", ym_cs_n, 1);
    chk("rst_wr_n", ym_wr_n, 1);
    // single write, cen always high
    n0 = obs_ev.size();
    push_m(0, 8'h28, 8'hF0);
    chk("busy_after_push", idle, 0);
    wait_idle(200, k);
    chk("idle_latency", k, 3 + WA + WD);
    if (obs_t.size() >= n0 + 2) chk("addr_to_data", obs_t[n0 + 1] - obs_t[n0], 1 + WA);
    check_events("single", n0, 1);
    // cen one pulse in six
    cen_mode = 1;
    ph = 0;
    n0 = obs_ev.size();
    push_m(1, 8'h30, 8'h71);
    wait_idle(1000, k);
    if (obs_t.size() >= n0 + 2) chk("cen6_gap", obs_t[n0 + 1] - obs_t[n0], (1 + WA) * 6);
    check_events("cen6", n0, 6);
    cen_mode = 0;
    // overflow while busy
    reset_dut();
    n0 = obs_ev.size();
    push_rand();
    tick();
    for (int i = 0; i < DEPTH; i++) push_rand();
    chk("burst_full", full, 1);
    chk("burst_level", level, DEPTH);
    chk("burst_ovf_pre", ovf, 0);
    push(1'($urandom), rreg(), 8'($urandom));
    chk("drop_ovf", ovf, 1);
    chk("drop_level", level, DEPTH);
    chk("drop_full", full, 1);
    wait_idle(2000, k);
    check_events("burst", n0, 1);
    chk("ovf_sticky", ovf, 1);
    // push coinciding with pop while full
    reset_dut();
    chk("ovf_cleared", ovf, 0);
    n0 = obs_ev.size();
    push_rand();
    e0 = t_cnt;
    tick();
    for (int i = 0; i < DEPTH; i++) push_rand();
    while (t_cnt < e0 + WA + WD + 3) tick();
    chk("pre_pop_full", full, 1);
    push_rand();
    chk("pop_push_level", level, DEPTH);
    chk("pop_push_full", full, 1);
    chk("pop_push_ovf", ovf, 0);
    wait_idle(2000, k);
    check_events("fullpop", n0, 1);
    // reset during the data strobe
    reset_dut();
    push(0, 8'h10, 8'h55);
    push(1, 8'h20, 8'h66);
    push(0, 8'h30, 8'h77);
    k = 0;
    while (!(ym_wr_n == 1'b0 && ym_addr[0]) && k < 40) begin
      tick();
      k++;
    end
    chk("data_strobe_seen", k < 40, 1);
    chk("data_din", ym_din, 8'h55);
    rst = 1;
    tick();
    chk("mid_rst_cs_n", ym_cs_n, 1);
    chk("mid_rst_wr_n", ym_wr_n, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    rst = 0;
    m_v = 0;
    n1 = obs_ev.size();
    repeat (100) tick();
    chk("no_activity", obs_ev.size(), n1);
    chk("quiet_idle", idle, 1);
    // repeated register writes (DAC streaming)
    reset_dut();
    n0 = obs_ev.size();
    for (int i = 0; i < 3; i++) begin
      r = 8'h80 + 8'(i);
      push_m(0, 8'h2A, r);
    end
    wait_idle(500, k);
`ifdef JT12_WRQ_ADDR_SKIP_EN
    if (obs_t.size() >= n0 + 4) begin
      chk("dac_space1", obs_t[n0 + 2] - obs_t[n0 + 1] - 1, WD + 1);
      chk("dac_space2", obs_t[n0 + 3] - obs_t[n0 + 2] - 1, WD + 1);
    end
`endif
    check_events("dac", n0, 1);
    // randomized traffic under three cen patterns
    for (int rd = 0; rd < 6; rd++) begin
      cen_mode = rd % 3;
      reset_dut();
      n0 = obs_ev.size();
      n1 = $urandom_range(1, 8);
      for (int i = 0; i < n1; i++) begin
        repeat ($urandom_range(0, 40)) tick();
        push_rand();
      end
      wait_idle(6000, k);
      check_events("rand", n0, cen_mode == 0 ? 1 : (cen_mode == 1 ? 6 : 0));
      chk("rand_ovf", ovf, 0);
      chk("rand_level", level, 0);
    end
    cen_mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
